alu_multicycle: RTL and testbench
=================================

// Module: alu_multicycle
// PURPOSE
//  Parametrised multi-cycle ALU: single-cycle logic/add/sub/slt, iterative unsigned multiply and divide.
//  Replaces the combinational execute ALU where MUL/DIV cost must leave the critical path.
//  Valid/ready handshake on both sides lets the pipeline control logic stall around long operations.
// PARAMETERS
//  WIDTH    32  operand/result width in bits (>=4)
//  CNT_W    $clog2(WIDTH+1)  iteration counter width; derived, do not override
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  flush      in   1      synchronous abort of any in-flight or held operation
//  in_valid   in   1      operand/op presented
//  in_ready   out  1      unit can accept; high only in IDLE and flush=0
//  op         in   3      000 AND, 001 OR, 010 ADD, 011 DIVU, 100 SUB, 101 MUL, 110 SLT, 111 REMU
//  src_a      in   WIDTH  operand A
//  src_b      in   WIDTH  operand B
//  out_valid  out  1      result valid; held until taken
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  registered result
//  zero_f     out  1      registered: result == 0
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, out_valid=0, result=0, zero_f=0, counter=0, internal regs=0.
//  Accept: in_valid & in_ready at edge N; op/src_a/src_b captured at that edge.
//  FSM: IDLE -> DONE (single-cycle ops) | BUSY (MUL/DIVU/REMU); BUSY -> DONE when counter hits WIDTH;
//       DONE -> IDLE when out_ready=1; any state -> IDLE on flush (flush wins over everything but rst).
//  Latency: single-cycle ops out_valid high at N+1; MUL/DIVU/REMU out_valid high at N+WIDTH+1.
//  in_ready=0 in BUSY and DONE (no accept/retire overlap); next accept earliest one cycle after retire.
//  out_valid=1 only in DONE; result/zero_f stable while out_valid=1 and out_ready=0.
//  Arithmetic, all modulo 2^WIDTH: ADD/SUB wrap, no carry/overflow flags.
//   SLT: signed two's-complement compare, result = {WIDTH-1 zeros, (A<B)}.
//   MUL: shift-add, one bit of B per cycle, result = low WIDTH bits of A*B (unsigned).
//   DIVU/REMU: restoring division, one quotient bit per cycle, unsigned.
//   B==0: DIVU result = all ones, REMU result = A; still takes WIDTH cycles (no early exit).
//  zero_f computed from the final registered result for every op.
//  flush in BUSY: op discarded, out_valid stays 0. flush in DONE: result dropped, out_valid=0 next cycle.
//  flush together with in_valid in IDLE: not accepted (in_ready=0 that cycle).
//  rst mid-operation: immediate return to reset values; no partial result ever becomes visible.
//  out_ready while out_valid=0: ignored. op/src changes while not accepting: ignored.
// STRUCTURE
//  Shared header alu_defs.vh: 3-bit opcode localparams (ALU_AND..ALU_REMU), FSM state encodings.
//  Sub-module alu_iter_unit: shift-add multiplier + restoring divider, start/done, shares one
//   WIDTH+1 adder and counter; top holds FSM, handshake, single-cycle datapath, output registers.
// TESTING
//  1 ADD 7+5, out_ready=1 -> out_valid at N+1, result=12, zero_f=0; SUB 5-5 -> result=0, zero_f=1.
//  2 SLT 0xFFFFFFFF vs 1 -> result=1; SLT 1 vs 0xFFFFFFFF -> 0; AND 0xF0F0 & 0xFF00 -> 0xF000.
//  3 MUL 0xFFFFFFFF*2 -> result=0xFFFFFFFE exactly at N+33, in_ready=0 from N+1 through N+33.
//  4 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9; each at N+33.
//  5 Hold out_ready=0 for 5 cycles after MUL 3*4 -> result=12 stable, in_ready=0; release -> IDLE next.
//  6 rst at N+10 of MUL, then flush at N+5 of DIVU -> out_valid never rises; following ADD 1+1 -> 2 at N+1.

Source files
------------

// File: rtl/alu_multicycle_pkg.sv
// rtl/alu_multicycle_pkg.sv - opcodes, FSM states and op classification for the multi-cycle ALU
package alu_multicycle_pkg;

   typedef enum logic [2:0] {
      ALU_AND  = 3'b000,
      ALU_OR   = 3'b001,
      ALU_ADD  = 3'b010,
      ALU_DIVU = 3'b011,
      ALU_SUB  = 3'b100,
      ALU_MUL  = 3'b101,
      ALU_SLT  = 3'b110,
      ALU_REMU = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } alu_state_e;

   function automatic logic is_iter_op(alu_op_e op);
      return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
   endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// rtl/alu_multicycle_if.sv - operand/result handshake bundle between pipeline control and the ALU
interface alu_multicycle_if
   import alu_multicycle_pkg::*;
#(
   parameter int WIDTH = 32
) ();

   logic             in_valid;
   logic             in_ready;
   alu_op_e          op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero_f;

   modport master (
      output in_valid, op, src_a, src_b, out_ready,
      input  in_ready, out_valid, result, zero_f
   );

   modport slave (
      input  in_valid, op, src_a, src_b, out_ready,
      output in_ready, out_valid, result, zero_f
   );

endinterface

// File: rtl/alu_multicycle_iter_unit.sv
// rtl/alu_multicycle_iter_unit.sv - shift-add multiplier and restoring divider sharing one adder and counter
module alu_iter_unit
   import alu_multicycle_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             abort_i,
   input  alu_op_e          op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   // p: product / remainder, q: multiplier / quotient, m: multiplicand / divisor
   logic             busy_q;
   logic             is_mul_q;
   logic             is_rem_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] p_q, q_q, m_q;
   logic [WIDTH-1:0] p_d, q_d, m_d;
   logic [WIDTH:0]   add_x, add_y;
   logic [WIDTH+1:0] sum;
   logic             ge;
   logic             unused_sum_bit;

   always_comb begin
      add_x = is_mul_q ? {1'b0, p_q} : {p_q, q_q[WIDTH-1]};
      add_y = is_mul_q ? {1'b0, m_q} : ~{1'b0, m_q};
      sum   = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH + 1){1'b0}}, ~is_mul_q};
      ge    = sum[WIDTH+1];
   end

   assign unused_sum_bit = sum[WIDTH];

   always_comb begin
      p_d = p_q;
      q_d = q_q;
      m_d = m_q;
      if (is_mul_q) begin
         p_d = q_q[0] ? sum[WIDTH-1:0] : p_q;
         q_d = q_q >> 1;
         m_d = m_q << 1;
      end else begin
         // divisor zero always "fits": quotient all ones, remainder shifts back to A
         p_d = ge ? sum[WIDTH-1:0] : add_x[WIDTH-1:0];
         q_d = {q_q[WIDTH-2:0], ge};
      end
   end

   assign done_o   = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
   assign result_o = (is_mul_q || is_rem_q) ? p_d : q_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q   <= 1'b0;
         is_mul_q <= 1'b0;
         is_rem_q <= 1'b0;
         cnt_q    <= '0;
         p_q      <= '0;
         q_q      <= '0;
         m_q      <= '0;
      end else if (abort_i) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else if (start_i) begin
         busy_q   <= 1'b1;
         is_mul_q <= (op_i == ALU_MUL);
         is_rem_q <= (op_i == ALU_REMU);
         cnt_q    <= '0;
         p_q      <= '0;
         q_q      <= (op_i == ALU_MUL) ? b_i : a_i;
         m_q      <= (op_i == ALU_MUL) ? a_i : b_i;
      end else if (busy_q) begin
         p_q <= p_d;
         q_q <= q_d;
         m_q <= m_d;
         if (done_o) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multi-cycle ALU top: handshake FSM, single-cycle datapath, result registers
module alu_multicycle
   import alu_multicycle_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   alu_multicycle_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   alu_state_e       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] single_result;
   logic [WIDTH-1:0] iter_result;
   logic             iter_start;
   logic             iter_done;
   logic             accept;

   assign bus.in_ready  = (state_q == ST_IDLE) && !flush;
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.result    = result_q;
   assign bus.zero_f    = zero_q;
   assign accept        = bus.in_valid && bus.in_ready;

   always_comb begin
      single_result = '0;
      case (bus.op)
         ALU_AND: single_result = bus.src_a & bus.src_b;
         ALU_OR:  single_result = bus.src_a | bus.src_b;
         ALU_ADD: single_result = bus.src_a + bus.src_b;
         ALU_SUB: single_result = bus.src_a - bus.src_b;
         ALU_SLT: single_result = {{(WIDTH - 1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)};
         default: single_result = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      result_d   = result_q;
      zero_d     = zero_q;
      iter_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (is_iter_op(bus.op)) begin
                  state_d    = ST_BUSY;
                  iter_start = 1'b1;
               end else begin
                  state_d  = ST_DONE;
                  result_d = single_result;
                  zero_d   = (single_result == '0);
               end
            end
         end
         ST_BUSY: begin
            if (iter_done) begin
               state_d  = ST_DONE;
               result_d = iter_result;
               zero_d   = (iter_result == '0);
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   alu_iter_unit #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter (
      .clk      (clk),
      .rst      (rst),
      .start_i  (iter_start),
      .abort_i  (flush),
      .op_i     (bus.op),
      .a_i      (bus.src_a),
      .b_i      (bus.src_b),
      .done_o   (iter_done),
      .result_o (iter_result)
   );

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - scoreboard bench for alu_multicycle with directed vectors
module tb_alu_multicycle;
   import alu_multicycle_pkg::*;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] res;
      logic         z;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   n_pass  = 0;
   int   n_total = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   alu_multicycle_if #(.WIDTH(W)) bus ();

   alu_multicycle #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_out_valid", W'(1), W'(0));
         end else begin
            mon_e = sb_q.pop_front();
            check("result", bus.result, mon_e.res);
            check("zero_f", W'(bus.zero_f), W'(mon_e.z));
         end
      end
   end

   task automatic run_op(input string name, input alu_op_e op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_res,
                         input int exp_lat, input int hold_cycles);
      int   lat  = 0;
      logic seen = 1'b0;
      @(posedge clk); #1;
      bus.in_valid  = 1'b1;
      bus.op        = op;
      bus.src_a     = a;
      bus.src_b     = b;
      bus.out_ready = (hold_cycles == 0);
      @(negedge clk);
      check({name, "_in_ready_idle"}, W'(bus.in_ready), W'(1));
      sb_q.push_back(exp_t'{res: exp_res, z: (exp_res == '0)});
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.src_a    = W'($urandom);
      bus.src_b    = W'($urandom);
      while (lat < 100 && !seen) begin
         @(negedge clk);
         lat++;
         if (bus.out_valid) seen = 1'b1;
         if (exp_lat > 1) check({name, "_in_ready_busy"}, W'(bus.in_ready), W'(0));
      end
      check({name, "_latency"}, W'(lat), W'(exp_lat));
      if (hold_cycles > 0) begin
         for (int k = 0; k < hold_cycles; k++) begin
            @(negedge clk);
            check({name, "_hold_result"}, bus.result, exp_res);
            check({name, "_hold_valid"}, W'(bus.out_valid), W'(1));
            check({name, "_hold_in_ready"}, W'(bus.in_ready), W'(0));
         end
         @(posedge clk); #1;
         bus.out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         check({name, "_idle_after_release"}, W'(bus.in_ready), W'(1));
      end
   endtask

   initial begin
      int seen_v;
      rst           = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.op        = ALU_AND;
      bus.src_a     = '0;
      bus.src_b     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", W'(bus.out_valid), W'(0));
      check("reset_result", bus.result, W'(0));
      check("reset_zero_f", W'(bus.zero_f), W'(0));
      rst = 1'b0;

      run_op("add", ALU_ADD, 32'd7, 32'd5, 32'd12, 1, 0);
      run_op("sub", ALU_SUB, 32'd5, 32'd5, 32'd0, 1, 0);
      run_op("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 0);
      run_op("slt_pos", ALU_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1, 0);
      run_op("and", ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1, 0);
      run_op("or", ALU_OR, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1, 0);
      run_op("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1, 1, 0);
      run_op("mul", ALU_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33, 0);
      run_op("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
      run_op("remu", ALU_REMU, 32'd100, 32'd7, 32'd2, 33, 0);
      run_op("divu_by0", ALU_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 33, 0);
      run_op("remu_by0", ALU_REMU, 32'd9, 32'd0, 32'd9, 33, 0);
      run_op("mul_hold", ALU_MUL, 32'd3, 32'd4, 32'd12, 33, 5);

      // reset in the middle of a multiply
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.op       = ALU_MUL;
      bus.src_a    = 32'd3;
      bus.src_b    = 32'd4;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", W'(bus.out_valid), W'(0));
      check("midrst_result", bus.result, W'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      // flush in the middle of a divide
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.op       = ALU_DIVU;
      bus.src_a    = 32'd100;
      bus.src_b    = 32'd7;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      check("flush_in_ready", W'(bus.in_ready), W'(0));
      @(posedge clk); #1;
      flush  = 1'b0;
      seen_v = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.out_valid) seen_v++;
      end
      check("flush_no_out_valid", W'(seen_v), W'(0));

      // flush together with in_valid in IDLE must not accept
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.op       = ALU_ADD;
      bus.src_a    = 32'd3;
      bus.src_b    = 32'd3;
      flush        = 1'b1;
      @(negedge clk);
      check("flush_idle_in_ready", W'(bus.in_ready), W'(0));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      flush        = 1'b0;
      seen_v       = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (bus.out_valid) seen_v++;
      end
      check("flush_idle_no_accept", W'(seen_v), W'(0));

      run_op("add_after", ALU_ADD, 32'd1, 32'd1, 32'd2, 1, 0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("scoreboard_drained", W'(sb_q.size()), W'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule
